dct_xpose_pingpong: RTL

- Parametrised N×N ping-pong transpose buffer between the row (stage-1) and column (stage-2) 1-D DCT passes of the JPEG DCT pipeline.
- Accepts one N-element row vector per cycle and emits one N-element column vector per cycle over valid/ready handshakes.
- Two banks sustain full streaming throughput.
- Performs output width reduction: wrap (discard MSBs) or saturate, with per-beat overflow reporting and a per-block sideband tag.

---
 rtl/dct_pkg.sv | 33 +++
 rtl/dct_xpose_bank.sv | 35 +++
 rtl/dct_xpose_pingpong.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared widths and output-conversion helper for the JPEG DCT pipeline.
// sat_conv takes a sign-extended input and returns the narrowed value plus overflow.
package dct_pkg;

  localparam int N_DEF     = 8;
  localparam int W_IN_DEF  = 12;
  localparam int W_OUT_DEF = 11;
  localparam int TAG_W_DEF = 2;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } conv_t;

  // Wrap leaves val untouched; the caller's truncation to w_out drops the MSBs.
  function automatic conv_t sat_conv(
    input logic signed [31:0] x,
    input int                 w_out,
    input logic               sat
  );
    conv_t              r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi    = (32'sd1 <<< (w_out - 1)) - 32'sd1;
    lo    = -hi - 32'sd1;
    r.ovf = (x > hi) || (x < lo);
    r.val = x;
    if (sat && (x > hi)) r.val = hi;
    if (sat && (x < lo)) r.val = lo;
    return r;
  endfunction

endpackage

// File: rtl/dct_xpose_bank.sv
// One N x N transpose bank: row-wide write port, column-wide read port.
// The array is intentionally not reset.
module dct_xpose_bank
  import dct_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_IN_DEF,
  parameter int AW = $clog2(N)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [AW-1:0]  row_i,
  input  logic [N*W-1:0] wdata_i,
  input  logic [AW-1:0]  col_i,
  output logic [N*W-1:0] rdata_o
);

  logic [W-1:0] mem_q [N][N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int c = 0; c < N; c++) begin
        mem_q[row_i][c] <= wdata_i[c*W +: W];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N; i++) begin
      rdata_o[i*W +: W] = mem_q[i][col_i];
    end
  end

endmodule

// File: rtl/dct_xpose_pingpong.sv
// Ping-pong row-in / column-out transpose between the two 1-D DCT passes,
// with wrap/saturate narrowing, overflow flag and per-block tag.
module dct_xpose_pingpong
  import dct_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W_IN-1:0]  in_data,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               sat_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*W_OUT-1:0] out_data,
  output logic               out_first,
  output logic               out_last,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ovf
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [1:0]       full_q, full_d;
  logic [1:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [AW-1:0]    wr_row_q, wr_row_d;
  logic [AW-1:0]    rd_col_q, rd_col_d;
  logic [N*W_IN-1:0] rd_vec [2];
  logic             in_acc, out_acc;
  conv_t            cv;

  // rst gating keeps both handshakes quiet while reset is held.
  assign in_ready  = rst & ~full_q[wbank_q];
  assign out_valid = rst & full_q[rbank_q];
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_xpose_bank #(
      .N (N),
      .W (W_IN)
    ) u_bank (
      .clk     (clk),
      .we_i    (in_acc && (wbank_q == 1'(b))),
      .row_i   (wr_row_q),
      .wdata_i (in_data),
      .col_i   (rd_col_q),
      .rdata_o (rd_vec[b])
    );
  end

  always_comb begin
    full_d   = full_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wr_row_d = wr_row_q;
    rd_col_d = rd_col_q;
    if (in_acc) begin
      if (wr_row_q == '0) begin
        tag_d[wbank_q]  = in_tag;
        mode_d[wbank_q] = sat_mode;
      end
      if (wr_row_q == LAST) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wr_row_d        = '0;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    if (out_acc) begin
      if (rd_col_q == LAST) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        rd_col_d        = '0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q   <= '0;
      mode_q   <= '0;
      tag_q    <= '{default: '0};
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      wr_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      full_q   <= full_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      wr_row_q <= wr_row_d;
      rd_col_q <= rd_col_d;
    end
  end

  always_comb begin
    cv        = '0;
    out_data  = '0;
    out_ovf   = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_tag   = '0;
    if (out_valid) begin
      for (int i = 0; i < N; i++) begin
        cv = sat_conv(
          32'(signed'(rd_vec[rbank_q][i*W_IN +: W_IN])),
          W_OUT, mode_q[rbank_q]);
        out_data[i*W_OUT +: W_OUT] = W_OUT'(cv.val);
        out_ovf = out_ovf | cv.ovf;
      end
      out_first = (rd_col_q == '0);
      out_last  = (rd_col_q == LAST);
      out_tag   = tag_q[rbank_q];
    end
  end

endmodule
